// File: rtl/apb_master_fsm_pkg.sv
// Shared types and constants for the APB requester: FSM state encoding,
// APB response codes and the fixed protection attribute.
package apb_master_fsm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DERR   = 2'd3
   } apb_state_e;

   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic [1:0] RESP_SLVERR   = 2'b10;
   localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb_master_fsm_if.sv
// APB4 bus bundle between the requester (master) and the decoded completers (slave).
interface apb_master_fsm_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 4
);

   logic [NUM_SLAVES-1:0]   PSEL;
   logic                    PENABLE;
   logic                    PWRITE;
   logic [ADDR_WIDTH-1:0]   PADDR;
   logic [DATA_WIDTH-1:0]   PWDATA;
   logic [DATA_WIDTH/8-1:0] PSTRB;
   logic [2:0]              PPROT;
   logic [DATA_WIDTH-1:0]   PRDATA;
   logic                    PREADY;
   logic                    PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_master_fsm_decoder.sv
// Combinational completer decode: address index field -> one-hot select,
// flagging indices beyond the populated completers.
module apb_slave_decoder #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_SLAVES = 4,
   parameter int SEL_LSB    = 12,
   parameter int SEL_BITS   = 2
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [NUM_SLAVES-1:0] sel_o,
   output logic                  out_of_range_o
);

   logic [SEL_BITS-1:0] idx;

   assign idx = addr_i[SEL_LSB +: SEL_BITS];

   always_comb begin
      sel_o          = '0;
      out_of_range_o = (int'(idx) >= NUM_SLAVES);
      for (int i = 0; i < NUM_SLAVES; i++) begin
         sel_o[i] = (int'(idx) == i);
      end
   end

endmodule

// File: rtl/apb_master_fsm.sv
// APB4 requester: captures a one-cycle request, runs SETUP/ACCESS on the decoded
// completer with a PREADY timeout, and reports data, error and a done pulse.
module apb_master_fsm
   import apb_master_fsm_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVES     = 4,
   parameter int SEL_LSB        = 12,
   parameter int SEL_BITS       = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    transfer,
   input  logic                    read,
   input  logic                    write,
   input  logic [ADDR_WIDTH-1:0]   apb_waddr,
   input  logic [ADDR_WIDTH-1:0]   apb_raddr,
   input  logic [DATA_WIDTH-1:0]   apb_wdata,
   input  logic [DATA_WIDTH/8-1:0] PSTRB_in,
   output logic [DATA_WIDTH-1:0]   apb_rdata,
   output logic                    err_flag,
   output logic                    apb_done,
   output logic                    busy,
   apb_master_fsm_if.master        apb
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   apb_state_e            state_q, state_d;
   logic [NUM_SLAVES-1:0] psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [STRB_W-1:0]     pstrb_q, pstrb_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [ADDR_WIDTH-1:0] cap_addr;
   logic [ADDR_WIDTH-1:0] dec_addr;
   logic [NUM_SLAVES-1:0] dec_sel;
   logic                  dec_oor;
   logic                  timeout_hit;
   logic                  req_valid;
   logic [1:0]            resp;

   assign cap_addr  = write ? apb_waddr : apb_raddr;
   assign req_valid = transfer && (read || write);
   // In IDLE decode the address about to be captured so PSEL can be registered at capture.
   assign dec_addr  = (state_q == IDLE) ? cap_addr : paddr_q;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   apb_slave_decoder #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_LSB    (SEL_LSB),
      .SEL_BITS   (SEL_BITS)
   ) u_decoder (
      .addr_i         (dec_addr),
      .sel_o          (dec_sel),
      .out_of_range_o (dec_oor)
   );

   always_comb begin
      state_d  = state_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      done_d   = 1'b0;
      cnt_d    = cnt_q;
      resp     = RESP_OKAY;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               pwrite_d = write;
               paddr_d  = cap_addr;
               pwdata_d = apb_wdata;
               pstrb_d  = write ? PSTRB_in : '0;
               cnt_d    = '0;
               state_d  = dec_oor ? DERR : SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (apb.PREADY) begin
               resp    = apb.PSLVERR ? RESP_SLVERR : RESP_OKAY;
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = resp[1];
               if (!pwrite_q) rdata_d = apb.PRDATA;
            end else if (timeout_hit) begin
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
               if (!pwrite_q) rdata_d = '0;
            end else if (cnt_q != {CW{1'b1}}) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DERR: begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            if (!pwrite_q) rdata_d = '0;
         end
         default: state_d = IDLE;
      endcase

      psel_d    = ((state_d == SETUP) || (state_d == ACCESS)) ? dec_sel : '0;
      penable_d = (state_d == ACCESS);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= IDLE;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
      end
   end

   assign apb.PSEL    = psel_q;
   assign apb.PENABLE = penable_q;
   assign apb.PWRITE  = pwrite_q;
   assign apb.PADDR   = paddr_q;
   assign apb.PWDATA  = pwdata_q;
   assign apb.PSTRB   = pstrb_q;
   assign apb.PPROT   = PPROT_DEFAULT;
   assign apb_rdata   = rdata_q;
   assign err_flag    = err_q;
   assign apb_done    = done_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm: a 4-completer instance for the main sequences
// and a 3-completer instance for the out-of-range decode case.
module tb_apb_master_fsm;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        transfer_a, transfer_b;
   logic        read, write;
   logic [31:0] apb_waddr, apb_raddr, apb_wdata;
   logic [3:0]  PSTRB_in;
   logic [31:0] rdata_a, rdata_b;
   logic        err_a, err_b, done_a, done_b, busy_a, busy_b;

   int checks = 0;
   int errors = 0;

   apb_master_fsm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4)) bus_a ();
   apb_master_fsm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3)) bus_b ();

   apb_master_fsm #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(16)) dut_a (
      .ACLK(ACLK), .ARESET(ARESET), .transfer(transfer_a), .read(read), .write(write),
      .apb_waddr(apb_waddr), .apb_raddr(apb_raddr), .apb_wdata(apb_wdata), .PSTRB_in(PSTRB_in),
      .apb_rdata(rdata_a), .err_flag(err_a), .apb_done(done_a), .busy(busy_a), .apb(bus_a)
   );

   apb_master_fsm #(.NUM_SLAVES(3), .TIMEOUT_CYCLES(4)) dut_b (
      .ACLK(ACLK), .ARESET(ARESET), .transfer(transfer_b), .read(read), .write(write),
      .apb_waddr(apb_waddr), .apb_raddr(apb_raddr), .apb_wdata(apb_wdata), .PSTRB_in(PSTRB_in),
      .apb_rdata(rdata_b), .err_flag(err_b), .apb_done(done_b), .busy(busy_b), .apb(bus_b)
   );

   always #5 ACLK = ~ACLK;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // Leaves the caller observing cycle T+1, where T is the capturing edge.
   task automatic issue(input bit on_b, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
      write     = wr;
      read      = ~wr;
      apb_waddr = addr;
      apb_raddr = addr;
      apb_wdata = data;
      PSTRB_in  = strb;
      if (on_b) transfer_b = 1'b1; else transfer_a = 1'b1;
      step();
      transfer_a = 1'b0;
      transfer_b = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int pen_cnt;
      int done_cyc;

      ARESET = 1'b1; transfer_a = 0; transfer_b = 0; read = 0; write = 0;
      apb_waddr = '0; apb_raddr = '0; apb_wdata = '0; PSTRB_in = '0;
      bus_a.PREADY = 1'b1; bus_a.PSLVERR = 1'b0; bus_a.PRDATA = '0;
      bus_b.PREADY = 1'b1; bus_b.PSLVERR = 1'b0; bus_b.PRDATA = '0;
      step(); step();
      check_val("rst_psel",    bus_a.PSEL, 4'b0000);
      check_val("rst_penable", bus_a.PENABLE, 1'b0);
      check_val("rst_paddr",   bus_a.PADDR, 32'h0);
      check_val("rst_pwdata",  bus_a.PWDATA, 32'h0);
      check_val("rst_outs",    {rdata_a, err_a, done_a, busy_a}, 35'h0);
      ARESET = 1'b0;
      step();

      // Test 1: zero-wait write to completer 0
      issue(0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
      check_val("t1_setup_psel",    bus_a.PSEL, 4'b0001);
      check_val("t1_setup_penable", bus_a.PENABLE, 1'b0);
      check_val("t1_setup_ctrl",    {bus_a.PWRITE, bus_a.PSTRB, busy_a, done_a}, {1'b1, 4'hF, 1'b1, 1'b0});
      check_val("t1_pwdata",        bus_a.PWDATA, 32'hDEAD_BEEF);
      check_val("t1_pprot",         bus_a.PPROT, 3'b000);
      step();
      check_val("t1_access",        {bus_a.PSEL, bus_a.PENABLE, done_a}, {4'b0001, 1'b1, 1'b0});
      step();
      check_val("t1_done",          {done_a, err_a, busy_a}, {1'b1, 1'b0, 1'b0});
      check_val("t1_done_bus",      {bus_a.PSEL, bus_a.PENABLE}, 5'h0);
      step();
      check_val("t1_done_pulse",    done_a, 1'b0);

      // Ignored request: transfer with neither read nor write
      read = 0; write = 0; transfer_a = 1'b1;
      step();
      transfer_a = 1'b0;
      check_val("nop_busy", {busy_a, bus_a.PSEL}, 5'h0);

      // Test 2: read with two wait states on completer 1
      bus_a.PREADY = 1'b0;
      issue(0, 1'b0, 32'h0000_1008, 32'h0, 4'hA);
      check_val("t2_setup", {bus_a.PSEL, bus_a.PWRITE, bus_a.PSTRB}, {4'b0010, 1'b0, 4'h0});
      step();
      check_val("t2_access1", {bus_a.PENABLE, done_a}, 2'b10);
      step();
      check_val("t2_access2", {bus_a.PENABLE, done_a}, 2'b10);
      step();
      bus_a.PREADY = 1'b1; bus_a.PRDATA = 32'h1234_5678;
      check_val("t2_access3", {bus_a.PENABLE, done_a}, 2'b10);
      step();
      check_val("t2_done",  {done_a, err_a}, 2'b10);
      check_val("t2_rdata", rdata_a, 32'h1234_5678);
      bus_a.PRDATA = 32'hFFFF_0000;
      step();
      check_val("t2_hold",  {done_a, rdata_a}, {1'b0, 32'h1234_5678});

      // Test 3: write to completer 2 answered with PSLVERR
      bus_a.PSLVERR = 1'b1;
      issue(0, 1'b1, 32'h0000_2010, 32'hCAFE_0001, 4'h3);
      check_val("t3_setup_psel", bus_a.PSEL, 4'b0100);
      step(); step();
      check_val("t3_done", {done_a, err_a}, 2'b11);
      check_val("t3_rdata_kept", rdata_a, 32'h1234_5678);
      bus_a.PSLVERR = 1'b0;
      step();

      // Test 4: read with PREADY stuck low hits the timeout; a transfer while busy is dropped
      bus_a.PREADY = 1'b0;
      issue(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
      check_val("t4_setup_psel", bus_a.PSEL, 4'b1000);
      pen_cnt = 0; done_cyc = 0;
      for (int i = 2; i <= 40; i++) begin
         step();
         if (bus_a.PENABLE) pen_cnt++;
         if (done_a) begin
            done_cyc = i;
            break;
         end
         if (i == 5) begin
            check_val("t4_busy_on_drop", busy_a, 1'b1);
            write = 1'b1; read = 1'b0; apb_waddr = 32'h0000_0000; transfer_a = 1'b1;
         end
         if (i == 6) begin
            transfer_a = 1'b0; write = 1'b0; read = 1'b1;
            check_val("t4_drop_paddr", bus_a.PADDR, 32'h0000_3000);
         end
      end
      check_val("t4_done_cycle", done_cyc, 18);
      check_val("t4_penable_cycles", pen_cnt, 16);
      check_val("t4_err_rdata", {err_a, rdata_a}, {1'b1, 32'h0});
      bus_a.PREADY = 1'b1;
      step();

      // Test 5: 3-completer instance, valid read then out-of-range read
      bus_b.PRDATA = 32'h55AA_55AA;
      issue(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
      check_val("t5_valid_psel", bus_b.PSEL, 3'b010);
      step(); step();
      check_val("t5_valid_done", {done_b, err_b, rdata_b}, {1'b1, 1'b0, 32'h55AA_55AA});
      step();
      issue(1, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
      check_val("t5_derr_t1", {bus_b.PSEL, bus_b.PENABLE, busy_b, done_b}, {3'b000, 1'b0, 1'b1, 1'b0});
      step();
      check_val("t5_derr_t2", {bus_b.PSEL, done_b, err_b}, {3'b000, 1'b1, 1'b1});
      check_val("t5_derr_rdata", rdata_b, 32'h0);
      step();
      check_val("t5_done_pulse", done_b, 1'b0);

      // Test 6: reset in the second ACCESS cycle, then a normal write
      bus_a.PREADY = 1'b0;
      issue(0, 1'b1, 32'h0000_1004, 32'h7777_7777, 4'hF);
      step();
      check_val("t6_access1", bus_a.PENABLE, 1'b1);
      step();
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      check_val("t6_rst_bus", {bus_a.PSEL, bus_a.PENABLE, bus_a.PWRITE, bus_a.PSTRB}, 10'h0);
      check_val("t6_rst_addr", {bus_a.PADDR, bus_a.PWDATA}, 64'h0);
      check_val("t6_rst_outs", {done_a, busy_a, err_a, rdata_a}, 35'h0);
      step();
      check_val("t6_no_done", {done_a, busy_a}, 2'b00);
      bus_a.PREADY = 1'b1;
      issue(0, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, 4'hC);
      check_val("t6_new_setup", {bus_a.PSEL, bus_a.PWDATA}, {4'b0001, 32'h0BAD_F00D});
      step(); step();
      check_val("t6_new_done", {done_a, err_a}, 2'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
